// File: rtl/as2650_sram_pkg.sv
// Shared types and constants for the AS2650 SRAM front end.
// Holds the controller state enum, macro geometry and the idle/reset pin values.
package as2650_sram_pkg;

    localparam int unsigned SRAM_DEPTH = 512;
    localparam int unsigned SRAM_AW    = 9;
    localparam int unsigned SRAM_DW    = 8;

    // WEN is active-low per bit: all ones masks every bit.
    localparam logic [SRAM_DW-1:0] WEN_NONE = 8'hFF;
    localparam logic [SRAM_DW-1:0] WEN_ALL  = 8'h00;

    typedef enum logic [1:0] {
        ST_CLEAR      = 2'd0,
        ST_IDLE       = 2'd1,
        ST_RD_ISSUE   = 2'd2,
        ST_RD_CAPTURE = 2'd3
    } state_e;

    // Registered pin bundle presented to the macro.
    typedef struct packed {
        logic               cen;
        logic               gwen;
        logic [SRAM_DW-1:0] wen;
        logic [SRAM_AW-1:0] a;
        logic [SRAM_DW-1:0] d;
    } sram_pins_t;

    localparam sram_pins_t PINS_RESET = '{
        cen:  1'b1,
        gwen: 1'b1,
        wen:  WEN_NONE,
        a:    SRAM_AW'(0),
        d:    SRAM_DW'(0)
    };

endpackage

// File: rtl/as2650_sram_ctrl.sv
// Request/response front end for the 512x8 GF180 SRAM macro wrapper.
// Ports:
//   clk, rst_n                      : clock (shared with macro CLK), async active-low reset
//   req_valid/req_ready/req_we/...  : byte read / bit-masked write request handshake
//   rsp_valid/rsp_ready/rsp_rdata   : registered read response with backpressure
//   init_done                       : zero-fill sweep finished
//   sram_cen/gwen/wen/a/d, sram_q   : macro pins, all driven straight from flops
module as2650_sram_ctrl
    import as2650_sram_pkg::*;
#(
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter int unsigned DEPTH          = SRAM_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [SRAM_AW-1:0] req_addr,
    input  logic [SRAM_DW-1:0] req_wdata,
    input  logic [SRAM_DW-1:0] req_wmask,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [SRAM_DW-1:0] rsp_rdata,
    output logic               init_done,
    output logic               sram_cen,
    output logic               sram_gwen,
    output logic [SRAM_DW-1:0] sram_wen,
    output logic [SRAM_AW-1:0] sram_a,
    output logic [SRAM_DW-1:0] sram_d,
    input  logic [SRAM_DW-1:0] sram_q
);

    // One extra count bit gives the sweep a terminal value one past the last
    // address, which is the cycle spent handing over to IDLE.
    localparam int unsigned     CNT_W   = SRAM_AW + 1;
    localparam logic [CNT_W-1:0] CLR_END = CNT_W'(DEPTH);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   clr_cnt_q,   clr_cnt_d;
    sram_pins_t         pins_q,      pins_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [SRAM_DW-1:0] rsp_rdata_q, rsp_rdata_d;
    logic               init_done_q, init_done_d;
    logic               req_ready_c;

    // Accept only in IDLE and only when the response slot is free or draining this edge.
    assign req_ready_c = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready);

    // Next-state, pin and response logic.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        pins_d      = pins_q;
        pins_d.cen  = 1'b1;
        pins_d.gwen = 1'b1;
        pins_d.wen  = WEN_NONE;
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;

        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_END) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                    clr_cnt_d   = CNT_W'(0);
                end else begin
                    pins_d.cen  = 1'b0;
                    pins_d.gwen = 1'b0;
                    pins_d.wen  = WEN_ALL;
                    pins_d.a    = clr_cnt_q[SRAM_AW-1:0];
                    pins_d.d    = SRAM_DW'(0);
                    clr_cnt_d   = clr_cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid && req_ready_c) begin
                    if (req_we) begin
                        // An all-zero mask is consumed without touching the macro.
                        if (req_wmask != SRAM_DW'(0)) begin
                            pins_d.cen  = 1'b0;
                            pins_d.gwen = 1'b0;
                            pins_d.wen  = ~req_wmask;
                            pins_d.a    = req_addr;
                            pins_d.d    = req_wdata;
                        end
                    end else begin
                        pins_d.cen = 1'b0;
                        pins_d.a   = req_addr;
                        state_d    = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAPTURE;
            end
            ST_RD_CAPTURE: begin
                rsp_rdata_d = sram_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clr_cnt_q   <= CNT_W'(0);
            pins_q      <= PINS_RESET;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= SRAM_DW'(0);
            init_done_q <= !CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            pins_q      <= pins_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign req_ready = req_ready_c;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;
    assign sram_cen  = pins_q.cen;
    assign sram_gwen = pins_q.gwen;
    assign sram_wen  = pins_q.wen;
    assign sram_a    = pins_q.a;
    assign sram_d    = pins_q.d;

endmodule
